key_count_ctrl: RTL and testbench
=================================

KEY_COUNT_CTRL -- requirements
Module: key_count_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: number of stable cycles needed to accept a key change (1 ms at 50 MHz).
REQ-002 Parameter REP_DELAY, default 25000000: hold time from the first step to the start of auto-repeat (0.5 s).
REQ-003 Parameter REP_PERIOD, default 5000000: interval between auto-repeat steps (0.1 s).
REQ-004 Parameter SAT, default 0: 1 suppresses steps at the counter's terminal count; 0 lets the counter wrap.
REQ-005 Internal counter widths SHALL be derived from the parameters with CLogB2 from MathFun.vh.
REQ-006 clk  input  1  clock; all logic updates on the rising edge.
REQ-007 reset  input  1  reset, synchronous and active-high.
REQ-008 key_up_n  input  1  raw push-button, active-low, asynchronous to clk; requests count up.
REQ-009 key_dn_n  input  1  raw push-button, active-low, asynchronous to clk; requests count down.
REQ-010 tc  input  1  terminal-count flag fed back from the downstream counter.
REQ-011 enable  output  1  one-cycle step strobe to the counter's enable input.
REQ-012 up_down  output  1  direction to the counter: 1 = up, 0 = down.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-014 Each key SHALL have its own debouncer with a stable state and a counter:
- the counter increments while the synchronized input differs from the stable state;
- the counter clears to 0 on any cycle where they match;
- when the counter reaches DEB_CYCLES-1 while still differing, the stable state toggles and the counter clears.
REQ-015 A press event SHALL be the debounced state going released -> pressed; a release is the opposite transition.
REQ-016 The FSM SHALL have the states IDLE, FIRST, DELAY and REPEAT, plus a shared timer.
REQ-017 IDLE -> FIRST when exactly one key has a press event.
- up_down SHALL load 1 for key_up and 0 for key_dn on this transition.
- That key becomes the active key.
REQ-018 Simultaneous press events on both keys in IDLE SHALL be ignored; the FSM stays in IDLE.
REQ-019 FIRST SHALL last one cycle with the step request high, then go to DELAY with the timer cleared.
REQ-020 DELAY -> REPEAT when the timer reaches REP_DELAY-1; the timer clears on the transition.
REQ-021 REPEAT:
- step request high for one cycle each time the timer reaches REP_PERIOD-1;
- the timer clears and REPEAT continues.
REQ-022 From FIRST, DELAY or REPEAT, a release of the active key SHALL go to IDLE; this has priority over any step in that cycle.
REQ-023 Press or release events on the non-active key SHALL be ignored while the FSM is not in IDLE.
REQ-024 up_down SHALL change only on IDLE -> FIRST and hold its value in all other cycles.
REQ-025 enable = registered step request AND NOT (SAT AND tc).
- enable is the only combinational output path.
- tc in the step cycle reflects the new up_down.
REQ-026 Press latency: enable SHALL assert in cycle DEB_CYCLES+3 after the raw key first goes and stays low.
- Cycles are counted from the first rising edge that samples the low level.
REQ-027 enable SHALL never be high for two consecutive cycles.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL:
- set the FSM to IDLE;
- clear all counters and the timer;
- set the synchronizers and debounced states to released;
- drive enable=0 and up_down=1.
REQ-029 Reset SHALL act mid-operation in any state.
- The first cycle after reset is IDLE.
- A key held through reset SHALL produce a new press only after a full debounce from the released state.

Verification (DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, SAT=0 unless stated)
REQ-030 Tap: key_up_n low for 20 cycles, then high -> exactly one enable pulse at cycle 7, up_down=1, no further pulses.
REQ-031 Bounce: key_dn_n toggling every 2 cycles for 30 cycles, then high -> enable never asserted, up_down stays 1.
REQ-032 Hold: key_up_n held low for 40 cycles -> pulses at cycle 7, then at 7+1+10+3 = 21, then every 3 cycles; no pulse after the release is debounced.
REQ-033 Conflict: both keys fall in the same cycle -> no enable. Separately, key_dn held while key_up is pressed -> key_up ignored and up_down stays 0.
REQ-034 Saturation: SAT=1, tc=1 -> FSM sequences normally but enable stays 0. With tc=0 -> pulses as in REQ-032.
REQ-035 Reset mid-REPEAT: reset=1 for 1 cycle -> enable=0 and up_down=1 the next cycle. A still-held key produces its next pulse 7 cycles after reset deasserts.

Source files
------------

// File: rtl/key_count_ctrl.sv
// Two-key up/down step controller: synchronizes and debounces two push-buttons
// and issues one-cycle count strobes with hold-to-repeat.
module key_count_ctrl #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned REP_DELAY  = 25000000,
    parameter int unsigned REP_PERIOD = 5000000,
    parameter bit          SAT        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_up_n,
    input  logic key_dn_n,
    input  logic tc,
    output logic enable,
    output logic up_down
);

    // Ceiling log2 with a floor of one bit, used to size counters from parameters.
    function automatic int CLogB2(input int unsigned value);
        int unsigned v;
        int          bits;
        v    = (value > 0) ? value - 1 : 0;
        bits = 0;
        while (v != 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

    localparam int unsigned TMR_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int          DEB_W   = CLogB2(DEB_CYCLES);
    localparam int          TMR_W   = CLogB2(TMR_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REP_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        DELAY,
        REPEAT
    } state_t;

    // Bit 0 is the up key, bit 1 the down key; all levels are raw polarity (1 = released).
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       stable_prev_q, stable_prev_d;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];
    logic [1:0]       press_evt;
    logic [1:0]       rel_evt;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             step_q;
    logic             up_down_q;
    logic             active_q;

    always_comb begin
        sync1_d       = {key_dn_n, key_up_n};
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            stable_d[i]  = stable_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        press_evt = stable_prev_q & ~stable_q;
        rel_evt   = ~stable_prev_q & stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            deb_cnt_q     <= '{default: '0};
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            deb_cnt_q     <= deb_cnt_d;
        end
    end

    // A release of the active key wins over a step due in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            step_q    <= 1'b0;
            up_down_q <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (press_evt[0] ^ press_evt[1]) begin
                        state_q   <= FIRST;
                        step_q    <= 1'b1;
                        up_down_q <= press_evt[0];
                        active_q  <= press_evt[1];
                    end
                end
                FIRST: begin
                    timer_q <= '0;
                    state_q <= rel_evt[active_q] ? IDLE : DELAY;
                end
                DELAY: begin
                    if (rel_evt[active_q]) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (timer_q == DELAY_LAST) begin
                        state_q <= REPEAT;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rel_evt[active_q]) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (timer_q == PERIOD_LAST) begin
                        step_q  <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign enable  = step_q & ~(SAT & tc);
    assign up_down = up_down_q;

endmodule

// File: tb/tb_key_count_ctrl.sv
// Directed bench for key_count_ctrl: a SAT=0 and a SAT=1 instance share the keys,
// and a queue of expected strobe cycles is checked every cycle.
module tb_key_count_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic clk = 1'b0;
    logic reset;
    logic key_up_n;
    logic key_dn_n;
    logic tc;
    logic en0, ud0, en1, ud1;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic exp_dir;

    key_count_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .SAT(1'b0)) dut (
        .clk(clk), .reset(reset), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .tc(tc), .enable(en0), .up_down(ud0)
    );

    key_count_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .tc(tc), .enable(en1), .up_down(ud1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key first sampled low at edge t0+1; the FSM drops to IDLE at edge 'limit'.
    function automatic void schedule(input int t0, input int limit, input logic dir);
        int p;
        p = t0 + DEB + 3;
        if (p < limit) exp_q.push_back('{p, dir});
        p = t0 + DEB + 3 + 1 + RD + RP;
        while (p < limit) begin
            exp_q.push_back('{p, dir});
            p = p + RP;
        end
    endfunction

    task automatic cmp(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic checkOutput();
        logic hit;
        exp_t e;
        hit = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (hit) begin
            e       = exp_q.pop_front();
            exp_dir = e.dir;
        end
        cmp("enable", en0, hit);
        cmp("enable_sat", en1, hit & ~tc);
        cmp("up_down", ud0, exp_dir);
        cmp("up_down_sat", ud1, exp_dir);
    endtask

    task automatic applyStimulus(input logic up_n, input logic dn_n, input int n);
        key_up_n = up_n;
        key_dn_n = dn_n;
        repeat (n) begin
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        int   t0;
        logic b;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        tc       = 1'b0;
        reset    = 1'b1;
        exp_dir  = 1'b1;
        $display("[TB] reset");
        applyStimulus(1'b1, 1'b1, 3);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 5);

        $display("[TB] tap on key_up");
        t0 = cyc;
        schedule(t0, t0 + 10 + DEB + 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 20);

        $display("[TB] bouncing key_dn");
        for (int i = 0; i < 30; i++) begin
            b = ((i / 2) % 2) == 1;
            applyStimulus(1'b1, b, 1);
        end
        applyStimulus(1'b1, 1'b1, 15);

        $display("[TB] hold key_up");
        t0 = cyc;
        schedule(t0, t0 + 40 + DEB + 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 40);
        applyStimulus(1'b1, 1'b1, 20);

        $display("[TB] both keys together");
        applyStimulus(1'b0, 1'b0, 15);
        applyStimulus(1'b1, 1'b1, 15);

        $display("[TB] key_dn held while key_up pressed");
        t0 = cyc;
        schedule(t0, t0 + 30 + DEB + 3, 1'b0);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 20);

        $display("[TB] saturation with tc high");
        tc = 1'b1;
        t0 = cyc;
        schedule(t0, t0 + 40 + DEB + 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 40);
        applyStimulus(1'b1, 1'b1, 20);
        tc = 1'b0;

        $display("[TB] reset during repeat");
        t0 = cyc;
        schedule(t0, t0 + 27, 1'b0);
        applyStimulus(1'b1, 1'b0, 26);
        reset = 1'b1;
        @(negedge clk);
        exp_dir = 1'b1;
        checkOutput();
        reset = 1'b0;
        t0 = cyc;
        schedule(t0, t0 + 12 + DEB + 3, 1'b0);
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b1, 1'b1, 20);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("[TB] FAIL pending_pulses: observed %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
